// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, default width,
// and the iteration counter width.
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must hold WIDTH itself, so it needs log2(WIDTH+1) bits.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle between a multiplier client and the shift-add multiplier.
interface mult_if #(
    parameter int WIDTH = mult_pkg::WIDTH_DEF
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier_add_stage.sv
// WIDTH-bit ripple-carry adder; the per-step adder of the shift-add multiplier.
module add_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
        assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
    end

    assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: WIDTH conditional add + right-shift steps,
// using add_stage for the partial-sum addition.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    mult_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_s;
    logic               add_cout;
    logic               last_step;

    assign add_y     = acc[0] ? mcand : '0;
    assign last_step = (count == CW'(1));

    add_stage #(.WIDTH(WIDTH)) u_add (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (add_y),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // Carry lands in the top bit after the shift, so the sum never overflows.
    assign acc_nx = {add_cout, add_s, acc[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    mcand <= bus.a;
                    acc   <= {{WIDTH{1'b0}}, bus.b};
                    count <= CW'(WIDTH);
                end
                RUN: begin
                    acc   <= acc_nx;
                    count <= count - CW'(1);
                    if (last_step) product <= acc_nx;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized and directed checks of shift_add_multiplier against an arithmetic model.
module tb_shift_add_multiplier;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   last_prod;

    mult_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One multiplication; optionally pokes start/a/b while running to prove
    // they are ignored. Checks latency, busy width, held and final product.
    task automatic run_op(input int av, input int bv, input bit disturb);
        int nb;
        int done_at;
        int exp;
        exp = av * bv;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = W'(av);
        bus.b     = W'(bv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nb      = 0;
        done_at = -1;
        if (bus.busy) nb++;
        if (disturb) begin
            bus.a = W'(~av);
            bus.b = W'(bv + 3);
        end
        for (int k = 1; k <= 20; k++) begin
            if (disturb && k == 2) bus.start = 1'b1;
            if (disturb && k == 3) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (k == 1) chk("held", int'(bus.product), last_prod);
            if (bus.done) begin
                done_at = k;
                break;
            end
            if (bus.busy) nb++;
        end
        chk("latency", done_at, W);
        chk("busy_cycles", nb, W);
        chk("product", int'(bus.product), exp);
        last_prod = exp;
        @(posedge clk);
        #1;
        chk("done_pulse", int'(bus.done), 0);
    endtask

    initial begin
        int cyc;
        int prev_done;
        int ea;
        int eb;
        n_vec     = 0;
        n_err     = 0;
        last_prod = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_prod", int'(bus.product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3, 5, 1'b0);
        run_op(15, 15, 1'b0);
        run_op(0, 9, 1'b0);
        run_op(9, 0, 1'b0);
        run_op(10, 13, 1'b1);
        run_op(12, 11, 1'b0);
        run_op(1, 1, 1'b0);

        for (int i = 0; i < 20; i++)
            run_op(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom_range(1)));

        // Reset two steps into a run: everything clears at once, no waiting for an edge.
        run_op(14, 14, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd13;
        bus.b     = 4'd11;
        repeat (3) @(posedge clk);
        bus.start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_prod", int'(bus.product), 0);
        last_prod = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(7, 6, 1'b0);

        // Exhaustive with start held high: new operands are driven right after
        // each done so the re-trigger from IDLE picks them up.
        @(negedge clk);
        bus.start = 1'b1;
        cyc       = 0;
        prev_done = -1;
        for (int i = 0; i < 256; i++) begin
            bus.a = W'(i >> 4);
            bus.b = W'(i);
            ea = i >> 4;
            eb = i & 15;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                cyc++;
                if (bus.done) break;
            end
            if (i == 255) bus.start = 1'b0;
            chk("exh_prod", int'(bus.product), ea * eb);
            if (prev_done >= 0) chk("exh_spacing", cyc - prev_done, W + 2);
            prev_done = cyc;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
